// File: rtl/core_seq_ctrl_if.sv
// rtl/core_seq_ctrl_if.sv - host/core-facing bundle of the core_seq_ctrl instruction sequencer
//
// Ports (signals carried by the interface):
//   start        host -> seq   job start pulse, sampled only while idle
//   cfg_nkij     host -> seq   number of kernel positions (1..9, 0 = empty job)
//   cfg_len      host -> seq   activation vectors per kernel position
//   cfg_xbase    host -> seq   activation base address in xmem
//   cfg_wbase    host -> seq   weight base address in xmem
//   cfg_pbase    host -> seq   psum base address in pmem
//   cfg_relu     host -> seq   apply ReLU on the final accumulate pass
//   ofifo_valid  core -> seq   an output-fifo row is ready to drain
//   inst         seq  -> core  49-bit instruction word
//   busy         seq  -> host  job in progress
//   done         seq  -> host  one-cycle end-of-job pulse
// Modports: master = host/bench side, slave = sequencer side.

interface core_seq_ctrl_if #(
  parameter int addr_w = 11
);

  logic                  start;
  logic [3:0]            cfg_nkij;
  logic [addr_w-1:0]     cfg_len;
  logic [addr_w-1:0]     cfg_xbase;
  logic [addr_w-1:0]     cfg_wbase;
  logic [addr_w-1:0]     cfg_pbase;
  logic                  cfg_relu;
  logic                  ofifo_valid;
  logic [3*addr_w+15:0]  inst;
  logic                  busy;
  logic                  done;

  modport master (
    output start, cfg_nkij, cfg_len, cfg_xbase, cfg_wbase, cfg_pbase, cfg_relu,
    output ofifo_valid,
    input  inst, busy, done
  );

  modport slave (
    input  start, cfg_nkij, cfg_len, cfg_xbase, cfg_wbase, cfg_pbase, cfg_relu,
    input  ofifo_valid,
    output inst, busy, done
  );

endinterface

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - weight-stationary instruction sequencer for core
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    core_seq_ctrl_if.slave: start/cfg_* job descriptor, ofifo_valid from
//          core, registered inst/busy/done outputs
//
// Each kernel position runs WLD -> KLD -> XLD -> EXE -> DRN; after the last one
// an ACC pass reads every psum back (j outer, k inner), then FIN pulses done.
// All outputs are registered: the word for cycle t is built from the state and
// counters being entered at edge t, so inst is a pure function of next-state.

module core_seq_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int addr_w = 11
) (
  input  logic             clk,
  input  logic             reset,
  core_seq_ctrl_if.slave   bus
);

  localparam int inst_w = 3*addr_w + 16;

  // xmem/pmem/wmem disabled (CEN=WEN=1), every other field zero.
  localparam logic [inst_w-1:0] idle_word = {
    3'b000,                          // mode, relu, accumulate
    2'b11, {addr_w{1'b0}},           // wmem CEN, WEN, A
    2'b11, {addr_w{1'b0}},           // pmem CEN, WEN, A
    2'b11, {addr_w{1'b0}},           // xmem CEN, WEN, A
    7'b0000000                       // ofifo_rd .. load
  };

  localparam logic [addr_w-1:0] a_one      = addr_w'(1);
  localparam logic [addr_w-1:0] row_a      = addr_w'(row);
  localparam logic [addr_w-1:0] kld_last_a = addr_w'(row + col - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLD,
    S_KLD,
    S_XLD,
    S_EXE,
    S_DRN,
    S_ACC,
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  // Phase cycle counter; doubles as pop count in DRN and as j in ACC.
  logic [addr_w-1:0]   cnt_q, cnt_d;
  // Kernel position index; doubles as the inner k loop in ACC.
  logic [3:0]          k_q, k_d;

  logic [3:0]          nkij_q, nkij_d;
  logic [addr_w-1:0]   len_q, len_d;
  logic [addr_w-1:0]   xbase_q, xbase_d;
  logic [addr_w-1:0]   wbase_q, wbase_d;
  logic [addr_w-1:0]   pbase_q, pbase_d;
  logic                relu_q, relu_d;

  logic [inst_w-1:0]   inst_q, inst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Set when the word being built is an ofifo pop in DRN.
  logic                pop;

  // Instruction fields for the word being built.
  logic                f_load, f_exec, f_l0_wr, f_l0_rd, f_ofifo_rd;
  logic                f_x_cen, f_p_cen, f_p_wen, f_acc, f_relu;
  logic [addr_w-1:0]   f_x_a, f_p_a;
  logic [addr_w-1:0]   k_ext, kl_off, kr_off;

  // ---------------------------------------------------------------------------
  // Next-state / counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    nkij_d  = nkij_q;
    len_d   = len_q;
    xbase_d = xbase_q;
    wbase_d = wbase_q;
    pbase_d = pbase_q;
    relu_d  = relu_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          nkij_d  = bus.cfg_nkij;
          len_d   = bus.cfg_len;
          xbase_d = bus.cfg_xbase;
          wbase_d = bus.cfg_wbase;
          pbase_d = bus.cfg_pbase;
          relu_d  = bus.cfg_relu;
          cnt_d   = '0;
          k_d     = '0;
          // An empty job touches no memory at all.
          if (bus.cfg_nkij == 4'd0 || bus.cfg_len == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_WLD;
          end
        end
      end

      S_WLD: begin
        if (cnt_q == row_a) begin
          state_d = S_KLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + a_one;
        end
      end

      S_KLD: begin
        if (cnt_q == kld_last_a) begin
          state_d = S_XLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + a_one;
        end
      end

      S_XLD: begin
        if (cnt_q == len_q) begin
          state_d = S_EXE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + a_one;
        end
      end

      S_EXE: begin
        if (cnt_q == len_q - a_one) begin
          // The first DRN word is decided here, so a ready ofifo is popped
          // in the very first drain cycle.
          state_d = S_DRN;
          if (bus.ofifo_valid) begin
            pop   = 1'b1;
            cnt_d = a_one;
          end else begin
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + a_one;
        end
      end

      S_DRN: begin
        // cnt_q counts pops already issued, including the one on inst now.
        if (cnt_q == len_q) begin
          cnt_d = '0;
          if (k_q == nkij_q - 4'd1) begin
            state_d = S_ACC;
            k_d     = '0;
          end else begin
            state_d = S_WLD;
            k_d     = k_q + 4'd1;
          end
        end else if (bus.ofifo_valid) begin
          pop   = 1'b1;
          cnt_d = cnt_q + a_one;
        end
      end

      S_ACC: begin
        if (k_q == nkij_q - 4'd1) begin
          k_d = '0;
          if (cnt_q == len_q - a_one) begin
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q + a_one;
          end
        end else begin
          k_d = k_q + 4'd1;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Instruction word for the state being entered
  // ---------------------------------------------------------------------------
  always_comb begin
    f_load     = 1'b0;
    f_exec     = 1'b0;
    f_l0_wr    = 1'b0;
    f_l0_rd    = 1'b0;
    f_ofifo_rd = 1'b0;
    f_x_cen    = 1'b1;
    f_x_a      = '0;
    f_p_cen    = 1'b1;
    f_p_wen    = 1'b1;
    f_p_a      = '0;
    f_acc      = 1'b0;
    f_relu     = 1'b0;

    // Offsets wrap modulo 2^addr_w by truncation.
    k_ext  = addr_w'(k_d);
    kl_off = k_ext * len_d;
    kr_off = k_ext * row_a;

    case (state_d)
      S_WLD: begin
        if (cnt_d < row_a) begin
          f_x_cen = 1'b0;
          f_x_a   = wbase_d + kr_off + cnt_d;
        end
        // Read data arrives one cycle after the address.
        f_l0_wr = (cnt_d != '0);
      end

      S_KLD: begin
        if (cnt_d < row_a) begin
          f_l0_rd = 1'b1;
          f_load  = 1'b1;
        end
      end

      S_XLD: begin
        if (cnt_d < len_d) begin
          f_x_cen = 1'b0;
          f_x_a   = xbase_d + kl_off + cnt_d;
        end
        f_l0_wr = (cnt_d != '0);
      end

      S_EXE: begin
        f_l0_rd = 1'b1;
        f_exec  = 1'b1;
      end

      S_DRN: begin
        if (pop) begin
          f_ofifo_rd = 1'b1;
          f_p_cen    = 1'b0;
          f_p_wen    = 1'b0;
          // cnt_d already counts this pop.
          f_p_a      = pbase_d + kl_off + cnt_d - a_one;
        end
      end

      S_ACC: begin
        f_p_cen = 1'b0;
        f_p_a   = pbase_d + kl_off + cnt_d;
        f_acc   = 1'b1;
        f_relu  = relu_d && (k_d == nkij_d - 4'd1);
      end

      default: begin
      end
    endcase

    inst_d = {
      1'b0, f_relu, f_acc,             // mode, relu, accumulate
      2'b11, {addr_w{1'b0}},           // wmem unused by this sequencer
      f_p_cen, f_p_wen, f_p_a,
      f_x_cen, 1'b1, f_x_a,            // xmem is only ever read
      f_ofifo_rd, 2'b00,               // ififo_wr, ififo_rd unused
      f_l0_rd, f_l0_wr, f_exec, f_load
    };

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      nkij_q  <= '0;
      len_q   <= '0;
      xbase_q <= '0;
      wbase_q <= '0;
      pbase_q <= '0;
      relu_q  <= 1'b0;
      inst_q  <= idle_word;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      nkij_q  <= nkij_d;
      len_q   <= len_d;
      xbase_q <= xbase_d;
      wbase_q <= wbase_d;
      pbase_q <= pbase_d;
      relu_q  <= relu_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - self-checking bench for core_seq_ctrl

module tb_core_seq_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam logic [48:0] IDLE_W = 49'h3001_800C_0000;

  typedef struct packed {
    logic [48:0] inst;
    logic        busy;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  core_seq_ctrl_if #(.addr_w(AW)) bus ();

  core_seq_ctrl #(.row(ROW), .col(COL), .addr_w(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Per-cycle expectations, consumed one per negedge by the compare process.
  exp_t        exp_q[$];
  // Expected instruction words for cycles 1..N of the job being modelled.
  logic [48:0] mq[$];
  // Hand-computed literal checks, handed to the compare process.
  string       lit_name[$];
  logic [63:0] lit_act[$];
  logic [63:0] lit_exp[$];

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = -1;
  int cen_cnt  = 0;
  int obs_x[$];
  int obs_pw[$];
  int obs_acc[$];
  int obs_relu[$];

  // Snapshot taken by the stimulus at each job start.
  int t0, x0, pw0, acc0, relu0, cen0;

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (bus.inst !== e.inst) begin
        n_fail++;
        $display("FAIL inst cyc=%0d got %h want %h", cyc, bus.inst, e.inst);
      end
      n_tests++;
      if (bus.busy !== e.busy) begin
        n_fail++;
        $display("FAIL busy cyc=%0d got %b want %b", cyc, bus.busy, e.busy);
      end
      n_tests++;
      if (bus.done !== e.done) begin
        n_fail++;
        $display("FAIL done cyc=%0d got %b want %b", cyc, bus.done, e.done);
      end
    end
    while (lit_name.size() > 0) begin
      string       nm;
      logic [63:0] a;
      logic [63:0] x;
      nm = lit_name.pop_front();
      a  = lit_act.pop_front();
      x  = lit_exp.pop_front();
      n_tests++;
      if (a !== x) begin
        n_fail++;
        $display("FAIL %s got %0h want %0h", nm, a, x);
      end
    end
    if (bus.inst[19] == 1'b0 && bus.inst[18] == 1'b1) obs_x.push_back(int'(bus.inst[17:7]));
    if (bus.inst[32] == 1'b0 && bus.inst[31] == 1'b0) obs_pw.push_back(int'(bus.inst[30:20]));
    if (bus.inst[32] == 1'b0 && bus.inst[31] == 1'b1) obs_acc.push_back(int'(bus.inst[30:20]));
    if (bus.inst[47] == 1'b1) obs_relu.push_back(int'(bus.inst[30:20]));
    if (bus.inst[19] == 1'b0 || bus.inst[32] == 1'b0 || bus.inst[45] == 1'b0) cen_cnt++;
    if (bus.done === 1'b1) done_cyc = cyc;
    cyc++;
  end

  task automatic lit(input string nm, input logic [63:0] a, input logic [63:0] x);
    lit_name.push_back(nm);
    lit_act.push_back(a);
    lit_exp.push_back(x);
  endtask

  function automatic logic [10:0] am(input int v);
    return 11'(v % 2048);
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: the whole job as a list of instruction words.
  // A drain stall of sn cycles is placed before pop sp of kernel position 0;
  // s0 returns the job cycle of the first stalled word.
  // ---------------------------------------------------------------------------
  task automatic build(input int nk, input int ln, input int xb, input int wb,
                       input int pb, input int rl, input int sp, input int sn,
                       output int s0);
    logic [48:0] w;
    s0 = -1;
    mq.delete();
    if (nk == 0 || ln == 0) begin
      mq.push_back(IDLE_W);
      return;
    end
    for (int k = 0; k < nk; k++) begin
      for (int i = 0; i <= ROW; i++) begin
        w = IDLE_W;
        if (i < ROW) begin w[19] = 1'b0; w[17:7] = am(wb + k*ROW + i); end
        if (i > 0) w[2] = 1'b1;
        mq.push_back(w);
      end
      for (int i = 0; i < ROW + COL; i++) begin
        w = IDLE_W;
        if (i < ROW) begin w[3] = 1'b1; w[0] = 1'b1; end
        mq.push_back(w);
      end
      for (int j = 0; j <= ln; j++) begin
        w = IDLE_W;
        if (j < ln) begin w[19] = 1'b0; w[17:7] = am(xb + k*ln + j); end
        if (j > 0) w[2] = 1'b1;
        mq.push_back(w);
      end
      for (int j = 0; j < ln; j++) begin
        w = IDLE_W; w[3] = 1'b1; w[1] = 1'b1;
        mq.push_back(w);
      end
      for (int d = 0; d < ln; d++) begin
        if (k == 0 && d == sp) begin
          s0 = mq.size() + 1;
          repeat (sn) mq.push_back(IDLE_W);
        end
        w = IDLE_W; w[6] = 1'b1; w[32] = 1'b0; w[31] = 1'b0;
        w[30:20] = am(pb + k*ln + d);
        mq.push_back(w);
      end
    end
    for (int j = 0; j < ln; j++) begin
      for (int k = 0; k < nk; k++) begin
        w = IDLE_W; w[32] = 1'b0; w[46] = 1'b1;
        w[30:20] = am(pb + k*ln + j);
        w[47] = (rl != 0) && (k == nk - 1);
        mq.push_back(w);
      end
    end
    mq.push_back(IDLE_W);
  endtask

  // ---------------------------------------------------------------------------
  // One job: start in cycle 0, cfg scrambled in cycle 1, optional second start
  // pulse in cycle dup, optional 2-cycle reset starting in cycle rst_at.
  // ---------------------------------------------------------------------------
  task automatic run_job(input int nk, input int ln, input int xb, input int wb,
                         input int pb, input int rl, input int sp, input int sn,
                         input int rst_at, input int dup);
    int s0;
    int n;
    int last;
    exp_t e;
    build(nk, ln, xb, wb, pb, rl, sp, sn, s0);
    n = mq.size();
    @(posedge clk); #1;
    bus.start       = 1'b1;
    bus.cfg_nkij    = 4'(nk);
    bus.cfg_len     = 11'(ln);
    bus.cfg_xbase   = 11'(xb);
    bus.cfg_wbase   = 11'(wb);
    bus.cfg_pbase   = 11'(pb);
    bus.cfg_relu    = (rl != 0);
    bus.ofifo_valid = 1'b1;
    t0 = cyc; x0 = obs_x.size(); pw0 = obs_pw.size(); acc0 = obs_acc.size();
    relu0 = obs_relu.size(); cen0 = cen_cnt;
    e = {IDLE_W, 1'b0, 1'b0};
    exp_q.push_back(e);
    last = (rst_at < 0) ? n : rst_at;
    for (int t = 1; t <= last; t++) begin
      e = {mq[t-1], 1'b1, (t == n)};
      exp_q.push_back(e);
    end
    if (rst_at >= 0) begin
      e = {IDLE_W, 1'b0, 1'b0};
      exp_q.push_back(e);
      exp_q.push_back(e);
      last = rst_at + 2;
    end else begin
      e = {IDLE_W, 1'b0, 1'b0};
      exp_q.push_back(e);
      last = n + 1;
    end
    for (int t = 1; t <= last; t++) begin
      @(posedge clk); #1;
      bus.start = (t == dup);
      if (t == 1) begin
        bus.cfg_nkij  = 4'd9;
        bus.cfg_len   = 11'd7;
        bus.cfg_xbase = 11'h123;
        bus.cfg_wbase = 11'h456;
        bus.cfg_pbase = 11'h789;
        bus.cfg_relu  = (rl == 0);
      end
      bus.ofifo_valid = !(s0 > 0 && t >= s0 - 1 && t < s0 - 1 + sn);
      reset = (rst_at >= 0 && (t == rst_at || t == rst_at + 1));
    end
    bus.start = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) lit("exp_drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    reset = 1'b1;
    bus.start = 1'b0; bus.cfg_nkij = '0; bus.cfg_len = '0; bus.cfg_xbase = '0;
    bus.cfg_wbase = '0; bus.cfg_pbase = '0; bus.cfg_relu = 1'b0; bus.ofifo_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    e = {IDLE_W, 1'b0, 1'b0};
    exp_q.push_back(e);
    lit("reset_inst", 64'(bus.inst), 64'(IDLE_W));
    reset = 1'b0;

    // Single kij; cfg changed after start, start re-pulsed while busy.
    run_job(1, 4, 'h40, 'h10, 'h80, 0, -1, 0, -1, 5);
    for (int i = 0; i < 8; i++) lit("a_wrd", 64'(obs_x[x0+i]), 64'('h10 + i));
    for (int i = 0; i < 4; i++) lit("a_xrd", 64'(obs_x[x0+8+i]), 64'('h40 + i));
    lit("a_xcnt", 64'(obs_x.size() - x0), 64'd12);
    for (int i = 0; i < 4; i++) lit("a_pwr", 64'(obs_pw[pw0+i]), 64'('h80 + i));
    for (int i = 0; i < 4; i++) lit("a_acc", 64'(obs_acc[acc0+i]), 64'('h80 + i));
    lit("a_done_at", 64'(done_cyc - t0), 64'd43);

    // Three kij with ReLU.
    run_job(3, 2, 'h40, 'h10, 'h80, 1, -1, 0, -1, -1);
    for (int i = 0; i < 8; i++) lit("b_wrd_k1", 64'(obs_x[x0+10+i]), 64'('h18 + i));
    lit("b_xrd_k1a", 64'(obs_x[x0+18]), 64'h42);
    lit("b_xrd_k1b", 64'(obs_x[x0+19]), 64'h43);
    begin
      int acc_ord[6] = '{'h80, 'h82, 'h84, 'h81, 'h83, 'h85};
      for (int i = 0; i < 6; i++) lit("b_acc_ord", 64'(obs_acc[acc0+i]), 64'(acc_ord[i]));
    end
    lit("b_relu_cnt", 64'(obs_relu.size() - relu0), 64'd2);
    lit("b_relu0", 64'(obs_relu[relu0]), 64'h84);
    lit("b_relu1", 64'(obs_relu[relu0+1]), 64'h85);
    lit("b_done_at", 64'(done_cyc - t0), 64'd103);

    // Drain stall of 5 cycles after the first pop.
    run_job(1, 4, 'h40, 'h10, 'h80, 0, 1, 5, -1, -1);
    for (int i = 0; i < 4; i++) lit("c_pwr", 64'(obs_pw[pw0+i]), 64'('h80 + i));
    lit("c_done_at", 64'(done_cyc - t0), 64'd48);

    // Empty jobs.
    run_job(1, 0, 'h40, 'h10, 'h80, 0, -1, 0, -1, -1);
    lit("d_done_at", 64'(done_cyc - t0), 64'd1);
    lit("d_no_cen", 64'(cen_cnt - cen0), 64'd0);
    run_job(0, 3, 'h40, 'h10, 'h80, 1, -1, 0, -1, -1);
    lit("d2_no_cen", 64'(cen_cnt - cen0), 64'd0);

    // Reset held two cycles in the middle of EXE, then a wrapping job.
    run_job(1, 4, 'h40, 'h10, 'h80, 0, -1, 0, 32, -1);
    run_job(1, 4, 'h40, 'h10, 'h7FE, 0, -1, 0, -1, -1);
    lit("e_pwr0", 64'(obs_pw[pw0]), 64'h7FE);
    lit("e_pwr1", 64'(obs_pw[pw0+1]), 64'h7FF);
    lit("e_pwr2", 64'(obs_pw[pw0+2]), 64'h000);
    lit("e_pwr3", 64'(obs_pw[pw0+3]), 64'h001);

    // Largest kernel count.
    run_job(9, 1, 'h7F0, 'h7C0, 'h7FA, 1, -1, 0, -1, -1);
    lit("f_done_at", 64'(done_cyc - t0), 64'd271);

    for (int i = 0; i < 8 && (lit_name.size() > 0 || exp_q.size() > 0); i++) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
